// File: rtl/scan_reader_pkg.sv
// Shared definitions for the scan_reader serial readout block.
// Holds the FSM state enumeration and the default parameter values that
// the top level and its sub-module use.
package scan_reader_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned BIT_CYCLES_DEF = 2;
  localparam int unsigned PARITY_EN_DEF  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

endpackage

// File: rtl/scan_reader_bit_timer.sv
// bit_timer: counts the clock cycles that each serial bit is held.
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-low clear
//   en   - count enable (high while a frame is in flight)
//   wrap - high on the last cycle of a bit (counter at BIT_CYCLES-1 while enabled)
module bit_timer
  import scan_reader_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  if (BIT_CYCLES == 1) begin : g_degen
    // Every enabled cycle is a complete bit; no counter state is needed.
    logic unused_clk_clr;
    assign unused_clk_clr = clk ^ clr;
    assign wrap           = en;
  end else begin : g_cnt
    localparam int unsigned CntW = $clog2(BIT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign wrap = en && (cnt_q == CntW'(BIT_CYCLES - 1));

    always_comb begin
      cnt_d = cnt_q;
      if (en) begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/scan_reader.sv
// scan_reader: captures a parallel snapshot of a DFF bank and shifts it out
// as a framed serial stream: START(0), data LSB-first, optional even parity,
// STOP(1). Each symbol is held BIT_CYCLES clocks.
// Ports:
//   clk     - rising-edge clock
//   clr     - asynchronous active-low clear; aborts any frame at once
//   d_in    - parallel word captured on an accepted load
//   load    - read request, accepted when ready=1
//   ready   - high only while idle
//   sout    - serial line, idles high
//   sout_en - high for every cycle of a frame
//   done    - one-cycle pulse in the first idle cycle after a frame
module scan_reader
  import scan_reader_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int unsigned PARITY_EN  = PARITY_EN_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_en,
  output logic             done
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              parity_q, parity_d;
  logic              ready_q, ready_d;
  logic              sout_q, sout_d;
  logic              sout_en_q, sout_en_d;
  logic              done_q, done_d;
  logic              wrap;
  logic              timer_en;

  assign timer_en = (state_q != StIdle);

  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .clr  (clr),
    .en   (timer_en),
    .wrap (wrap)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d  = StStart;
          shift_d  = d_in;
          parity_d = ^d_in;
          idx_d    = '0;
        end
      end
      StStart: begin
        if (wrap) state_d = StData;
      end
      StData: begin
        if (wrap) begin
          if (idx_q == IdxW'(WIDTH - 1)) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (wrap) state_d = StStop;
      end
      StStop: begin
        if (wrap) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they leave flops aligned
    // with the state they describe.
    ready_d   = (state_d == StIdle);
    sout_en_d = (state_d != StIdle);
    done_d    = (state_q == StStop) && wrap;

    unique case (state_d)
      StIdle:   sout_d = 1'b1;
      StStart:  sout_d = 1'b0;
      StData:   sout_d = shift_d[0];
      StParity: sout_d = parity_d;
      StStop:   sout_d = 1'b1;
      default:  sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      idx_q     <= '0;
      parity_q  <= 1'b0;
      ready_q   <= 1'b1;
      sout_q    <= 1'b1;
      sout_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      parity_q  <= parity_d;
      ready_q   <= ready_d;
      sout_q    <= sout_d;
      sout_en_q <= sout_en_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign sout    = sout_q;
  assign sout_en = sout_en_q;
  assign done    = done_q;

endmodule

// File: tb/tb_scan_reader.sv
// Self-checking bench for scan_reader. Three instances cover the default
// configuration, PARITY_EN=0, and the WIDTH=1/BIT_CYCLES=1 corner.
// Expected serial symbols are pushed to a queue when a load is driven and
// popped whenever the DUT drives a frame cycle.
module tb_scan_reader;

  logic       clk;
  logic       clr;
  logic [7:0] d_in;
  logic       load_a, load_b, load_c;
  logic       ready_a, sout_a, sout_en_a, done_a;
  logic       ready_b, sout_b, sout_en_b, done_b;
  logic       ready_c, sout_c, sout_en_c, done_c;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  scan_reader #(.WIDTH(8), .BIT_CYCLES(2), .PARITY_EN(1)) u_dut_a (
    .clk(clk), .clr(clr), .d_in(d_in), .load(load_a),
    .ready(ready_a), .sout(sout_a), .sout_en(sout_en_a), .done(done_a)
  );

  scan_reader #(.WIDTH(8), .BIT_CYCLES(2), .PARITY_EN(0)) u_dut_b (
    .clk(clk), .clr(clr), .d_in(d_in), .load(load_b),
    .ready(ready_b), .sout(sout_b), .sout_en(sout_en_b), .done(done_b)
  );

  scan_reader #(.WIDTH(1), .BIT_CYCLES(1), .PARITY_EN(1)) u_dut_c (
    .clk(clk), .clr(clr), .d_in(d_in[0:0]), .load(load_c),
    .ready(ready_c), .sout(sout_c), .sout_en(sout_en_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one frame: one queue entry per clock cycle.
  task automatic push_frame(input logic [7:0] data, input int w, input int bc, input bit par);
    bit p;
    p = 1'b0;
    for (int i = 0; i < w; i++) p = p ^ data[i];
    for (int k = 0; k < bc; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      for (int k = 0; k < bc; k++) exp_q.push_back(data[i]);
    end
    if (par) begin
      for (int k = 0; k < bc; k++) exp_q.push_back(p);
    end
    for (int k = 0; k < bc; k++) exp_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    tick();
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_a); end
    checks++; if (sout_a !== 1'b1) begin errors++; $display("FAIL reset_sout got %b want 1", sout_a); end
    checks++; if (sout_en_a !== 1'b0) begin errors++; $display("FAIL reset_sout_en got %b want 0", sout_en_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
    checks++; if (sout_c !== 1'b1 || ready_c !== 1'b1) begin
      errors++; $display("FAIL reset_c sout=%b ready=%b want 1 1", sout_c, ready_c);
    end
    clr = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit e;
    d_in = 8'hA5; load_a = 1'b1; push_frame(8'hA5, 8, 2, 1'b1);
    tick();
    load_a = 1'b0; d_in = 8'h00;
    for (int c = 1; c <= 23; c++) begin
      if (sout_en_a) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_sb c=%0d extra frame cycle", c); end
        else begin
          e = exp_q.pop_front();
          if (sout_a !== e) begin errors++; $display("FAIL basic_sout c=%0d got %b want %b", c, sout_a, e); end
        end
      end
      checks++; if (sout_en_a !== (c <= 22)) begin errors++; $display("FAIL basic_sout_en c=%0d got %b want %b", c, sout_en_a, (c <= 22)); end
      checks++; if (done_a !== (c == 23)) begin errors++; $display("FAIL basic_done c=%0d got %b want %b", c, done_a, (c == 23)); end
      checks++; if (ready_a !== (c == 23)) begin errors++; $display("FAIL basic_ready c=%0d got %b want %b", c, ready_a, (c == 23)); end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_parity();
    bit e;
    d_in = 8'h07; load_a = 1'b1; push_frame(8'h07, 8, 2, 1'b1);
    tick();
    load_a = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      if (sout_en_a) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL par_sb c=%0d extra frame cycle", c); end
        else begin
          e = exp_q.pop_front();
          if (sout_a !== e) begin errors++; $display("FAIL par_sout c=%0d got %b want %b", c, sout_a, e); end
        end
      end
      checks++; if (done_a !== (c == 23)) begin errors++; $display("FAIL par_done c=%0d got %b want %b", c, done_a, (c == 23)); end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL par_left got %0d want 0", exp_q.size()); exp_q.delete(); end

    // No parity slot: 20-cycle frame.
    load_b = 1'b1; push_frame(8'h07, 8, 2, 1'b0);
    tick();
    load_b = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (sout_en_b) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL nopar_sb c=%0d extra frame cycle", c); end
        else begin
          e = exp_q.pop_front();
          if (sout_b !== e) begin errors++; $display("FAIL nopar_sout c=%0d got %b want %b", c, sout_b, e); end
        end
      end
      checks++; if (sout_en_b !== (c <= 20)) begin errors++; $display("FAIL nopar_sout_en c=%0d got %b want %b", c, sout_en_b, (c <= 20)); end
      checks++; if (done_b !== (c == 21)) begin errors++; $display("FAIL nopar_done c=%0d got %b want %b", c, done_b, (c == 21)); end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL nopar_left got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_busy_load();
    bit e;
    d_in = 8'hA5; load_a = 1'b1; push_frame(8'hA5, 8, 2, 1'b1);
    tick();
    load_a = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      if (sout_en_a) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL busy_sb c=%0d extra frame cycle", c); end
        else begin
          e = exp_q.pop_front();
          if (sout_a !== e) begin errors++; $display("FAIL busy_sout c=%0d got %b want %b", c, sout_a, e); end
        end
      end
      checks++; if (ready_a !== (c == 23)) begin errors++; $display("FAIL busy_ready c=%0d got %b want %b", c, ready_a, (c == 23)); end
      checks++; if (done_a !== (c == 23)) begin errors++; $display("FAIL busy_done c=%0d got %b want %b", c, done_a, (c == 23)); end
      if (c == 5) begin d_in = 8'hFF; load_a = 1'b1; end
      if (c == 6) load_a = 1'b0;
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL busy_left got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    bit e;
    d_in = 8'hA5; load_a = 1'b1; push_frame(8'hA5, 8, 2, 1'b1);
    tick();
    for (int c = 1; c <= 47; c++) begin
      if (sout_en_a) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_sb c=%0d extra frame cycle", c); end
        else begin
          e = exp_q.pop_front();
          if (sout_a !== e) begin errors++; $display("FAIL b2b_sout c=%0d got %b want %b", c, sout_a, e); end
        end
      end
      checks++; if (done_a !== (c == 23 || c == 46)) begin
        errors++; $display("FAIL b2b_done c=%0d got %b want %b", c, done_a, (c == 23 || c == 46));
      end
      checks++; if (sout_en_a !== (c != 23 && c != 46 && c != 47)) begin
        errors++; $display("FAIL b2b_sout_en c=%0d got %b want %b", c, sout_en_a, (c != 23 && c != 46 && c != 47));
      end
      if (c == 23) push_frame(8'hA5, 8, 2, 1'b1);
      if (c == 46) load_a = 1'b0;
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_abort();
    bit e;
    d_in = 8'hA5; load_a = 1'b1; push_frame(8'hA5, 8, 2, 1'b1);
    tick();
    load_a = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (sout_en_a) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL abort_sb c=%0d extra frame cycle", c); end
        else begin
          e = exp_q.pop_front();
          if (sout_a !== e) begin errors++; $display("FAIL abort_sout c=%0d got %b want %b", c, sout_a, e); end
        end
      end
      if (c < 9) tick();
    end
    // Clear between edges; outputs must react with no clock edge.
    #2 clr = 1'b0;
    #1;
    checks++; if (sout_a !== 1'b1) begin errors++; $display("FAIL abort_sout got %b want 1", sout_a); end
    checks++; if (sout_en_a !== 1'b0) begin errors++; $display("FAIL abort_sout_en got %b want 0", sout_en_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", ready_a); end
    exp_q.delete();
    tick();
    clr = 1'b1;
    for (int c = 0; c < 30; c++) begin
      checks++; if (done_a !== 1'b0 || sout_en_a !== 1'b0) begin
        errors++; $display("FAIL abort_idle c=%0d done=%b sout_en=%b want 0 0", c, done_a, sout_en_a);
      end
      tick();
    end
    d_in = 8'h3C; load_a = 1'b1; push_frame(8'h3C, 8, 2, 1'b1);
    tick();
    load_a = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      if (sout_en_a) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL reload_sb c=%0d extra frame cycle", c); end
        else begin
          e = exp_q.pop_front();
          if (sout_a !== e) begin errors++; $display("FAIL reload_sout c=%0d got %b want %b", c, sout_a, e); end
        end
      end
      checks++; if (done_a !== (c == 23)) begin errors++; $display("FAIL reload_done c=%0d got %b want %b", c, done_a, (c == 23)); end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reload_left got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_edge_case();
    bit e;
    d_in = 8'h01; load_c = 1'b1; push_frame(8'h01, 1, 1, 1'b1);
    tick();
    load_c = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (sout_en_c) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL edge_sb c=%0d extra frame cycle", c); end
        else begin
          e = exp_q.pop_front();
          if (sout_c !== e) begin errors++; $display("FAIL edge_sout c=%0d got %b want %b", c, sout_c, e); end
        end
      end
      checks++; if (sout_en_c !== (c <= 4)) begin errors++; $display("FAIL edge_sout_en c=%0d got %b want %b", c, sout_en_c, (c <= 4)); end
      checks++; if (done_c !== (c == 5)) begin errors++; $display("FAIL edge_done c=%0d got %b want %b", c, done_c, (c == 5)); end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL edge_left got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    clr    = 1'b0;
    d_in   = 8'h00;
    load_a = 1'b0;
    load_b = 1'b0;
    load_c = 1'b0;
    #2;
    test_reset();
    test_basic();
    tick();
    test_parity();
    tick();
    test_busy_load();
    tick();
    test_back_to_back();
    tick();
    test_abort();
    tick();
    test_edge_case();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_reader.md
SCAN_READER -- requirements
Module: scan_reader

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (WIDTH >= 1).
REQ-002 The module SHALL have parameter BIT_CYCLES, default 2, giving the clock cycles each serial bit is held (BIT_CYCLES >= 1).
REQ-003 The module SHALL have parameter PARITY_EN, default 1; when 1, an even-parity bit is inserted after the data bits.
REQ-004 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 Port clr  input  1  reset, asynchronous and active-low; clr=0 clears all state immediately.
REQ-006 Port d_in  input  WIDTH  parallel snapshot of the DFF bank to be read out.
REQ-007 Port load  input  1  read request; the request is accepted on a rising edge where load=1 and ready=1.
REQ-008 Port ready  output  1  high only in IDLE; the block can accept a load.
REQ-009 Port sout  output  1  serial data line; idles high.
REQ-010 Port sout_en  output  1  high for every cycle of a frame, from START through STOP.
REQ-011 Port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; the PARITY state is skipped when PARITY_EN=0.
REQ-013 On an accepted load, the block SHALL capture d_in into an internal shift register on that same edge and enter START.
REQ-014 sout SHALL be 1 in IDLE, 0 in START, the data bits LSB-first in DATA, the even-parity bit (XOR of the captured word) in PARITY, and 1 in STOP.
REQ-015 Each of the states START, PARITY and STOP, and each data bit, SHALL last exactly BIT_CYCLES cycles, timed by a bit-cycle counter that wraps from BIT_CYCLES-1 to 0.
REQ-016 A bit-index counter of width clog2(WIDTH) SHALL advance once per data bit; DATA SHALL exit to PARITY or STOP when the index reaches WIDTH-1 and the bit-cycle counter wraps.
REQ-017 Frame length SHALL be (WIDTH + 2 + PARITY_EN) * BIT_CYCLES cycles; sout_en=1 for exactly those cycles.
REQ-018 After STOP the block SHALL return to IDLE, and done SHALL be 1 during the first IDLE cycle only.
REQ-019 A load accepted in the done cycle SHALL start a new frame, giving a one-cycle idle gap back-to-back.
REQ-020 load while ready=0 SHALL be ignored; changes on d_in after capture SHALL NOT affect the frame in flight.
REQ-021 With BIT_CYCLES=1 the bit-cycle counter SHALL be degenerate, and each bit SHALL last one cycle.

Reset
REQ-022 While clr=0 the outputs SHALL be: state=IDLE, ready=1, sout=1, sout_en=0, done=0; counters and the shift register SHALL be 0.
REQ-023 Asserting clr mid-frame SHALL abort the frame immediately with no done pulse, and the line SHALL return to sout=1 without waiting for a clock edge.
REQ-024 After clr is released, the first accepting edge SHALL be the first rising edge with load=1.

Structure
REQ-025 A shared package scan_reader_pkg SHALL hold the FSM state enumeration and the default constants WIDTH_DEF=8, BIT_CYCLES_DEF=2 and PARITY_EN_DEF=1.
REQ-026 The bit-cycle counter SHALL be a sub-module bit_timer with ports clk, clr, en and a wrap output; the FSM and shift register SHALL remain in scan_reader.

Verification
REQ-027 Basic frame: WIDTH=8, BIT_CYCLES=2, PARITY_EN=1, d_in=8'hA5, load at edge 0 -> sout = 0,1,0,1,0,0,1,0,1,0,1, each value held 2 cycles over cycles 1-22; done=1 at cycle 23.
REQ-028 Parity: d_in=8'h07 -> parity bit is 1; with PARITY_EN=0 the frame lasts 20 cycles and done=1 at cycle 21.
REQ-029 Busy load: pulse load at cycle 5 of a frame with d_in=8'hFF -> the frame still carries 8'hA5, and ready stays 0 until cycle 23.
REQ-030 Back-to-back: hold load=1 continuously -> a new START begins at cycle 24, and done pulses every 23 cycles.
REQ-031 Abort: clr=0 at cycle 9, asynchronous between edges -> sout=1, sout_en=0 and ready=1 immediately; no done pulse; the next load produces a full, correct frame.
REQ-032 Edge cases: BIT_CYCLES=1 with WIDTH=1 and d_in=1 -> sout = 0,1,1,1 over cycles 1-4; done=1 at cycle 5.
